// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencing and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the fetch_cnt / bubble_cnt performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pcF,
    input  logic [31:0] instrF,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pc_srcE,
    input  logic [31:0] pc_targetE,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc_plus4D,
    output logic        validD,
    output logic        misalign_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    // state  | meaning
    // S_BOOT | one cycle after reset: PC held at RESET_PC, IF/ID loads a bubble
    // S_RUN  | normal fetch with redirect / stall / flush handling
    typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic        r_misalign;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_ifid_load;
    logic        w_ifid_bubble;
    logic        w_misalign_next;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_BOOT;
        endcase
    end

    // A redirect both overrides stallF and squashes the instruction now in IF.
    always_comb begin
        w_pc_next       = r_pc;
        w_ifid_load     = 1'b0;
        w_ifid_bubble   = 1'b0;
        w_misalign_next = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_pc_next     = RESET_PC;
                w_ifid_bubble = 1'b1;
            end
            S_RUN: begin
                if (pc_srcE) begin
                    w_pc_next = {pc_targetE[31:2], 2'b00};
                end else if (!stallF) begin
                    w_pc_next = w_pc_plus4;
                end
                if (flushD || pc_srcE) begin
                    w_ifid_bubble = 1'b1;
                end else if (!stallD) begin
                    w_ifid_load = 1'b1;
                end
                w_misalign_next = pc_srcE && (pc_targetE[1:0] != 2'b00);
            end
            default: begin
                w_pc_next     = RESET_PC;
                w_ifid_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
            if (w_ifid_bubble) begin
                r_instr_d    <= NOP_INSTR;
                r_pc_d       <= 32'd0;
                r_pc_plus4_d <= 32'd0;
                r_valid_d    <= 1'b0;
            end else if (w_ifid_load) begin
                r_instr_d    <= instrF;
                r_pc_d       <= r_pc;
                r_pc_plus4_d <= w_pc_plus4;
                r_valid_d    <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_ifid_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            // BOOT bubbles are start-up, not pipeline hazards, so they are not counted.
            if (w_ifid_bubble && (r_state == S_RUN)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

    assign pcF          = r_pc;
    assign instrD       = r_instr_d;
    assign pcD          = r_pc_d;
    assign pc_plus4D    = r_pc_plus4_d;
    assign validD       = r_valid_d;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver queues the expected post-edge state, the monitor checks it.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] pcd;
        logic        mis;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n1, rst_n2;
    logic        stallF, stallD, flushD, pc_srcE;
    logic [31:0] pc_targetE;
    logic [31:0] pcF1, instrF1, instrD1, pcD1, pc_plus4D1;
    logic        validD1, mis1;
    logic [31:0] pcF2, instrF2, instrD2, pcD2, pc_plus4D2;
    logic        validD2, mis2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt1, bubble_cnt1, fetch_cnt2, bubble_cnt2;
`endif

    exp_t q1[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0003;
    endfunction

    assign instrF1 = imem(pcF1);
    assign instrF2 = imem(pcF2);

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .pcF(pcF1), .instrF(instrF1),
        .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .pc_srcE(pc_srcE), .pc_targetE(pc_targetE),
        .instrD(instrD1), .pcD(pcD1), .pc_plus4D(pc_plus4D1),
        .validD(validD1), .misalign_err(mis1)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt1), .bubble_cnt(bubble_cnt1)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .pcF(pcF2), .instrF(instrF2),
        .stallF(1'b0), .stallD(1'b0), .flushD(1'b0),
        .pc_srcE(1'b0), .pc_targetE(32'h0),
        .instrD(instrD2), .pcD(pcD2), .pc_plus4D(pc_plus4D2),
        .validD(validD2), .misalign_err(mis2)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt2), .bubble_cnt(bubble_cnt2)
`endif
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // IF/ID contents follow from (validD, pcD): a bubble is NOP/0/0, else imem(pcD)/pcD+4.
    task automatic compare(input string dut, input exp_t e, input logic [31:0] pc,
                           input logic v, input logic [31:0] ins, input logic [31:0] pd,
                           input logic [31:0] p4, input logic m);
        check32({dut, ".", e.tag, ".pcF"}, pc, e.pc);
        check32({dut, ".", e.tag, ".validD"}, {31'd0, v}, {31'd0, e.valid});
        check32({dut, ".", e.tag, ".pcD"}, pd, e.valid ? e.pcd : 32'd0);
        check32({dut, ".", e.tag, ".instrD"}, ins, e.valid ? imem(e.pcd) : NOP);
        check32({dut, ".", e.tag, ".pc_plus4D"}, p4, e.valid ? e.pcd + 32'd4 : 32'd0);
        check32({dut, ".", e.tag, ".misalign_err"}, {31'd0, m}, {31'd0, e.mis});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("dut1", e, pcF1, validD1, instrD1, pcD1, pc_plus4D1, mis1);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                compare("dut2", e, pcF2, validD2, instrD2, pcD2, pc_plus4D2, mis2);
            end
        end
    end

    task automatic step1(input string tag, input logic rst, input logic sf, input logic sd,
                         input logic fl, input logic src, input logic [31:0] tgt,
                         input logic [31:0] epc, input logic ev, input logic [31:0] epcd,
                         input logic emis);
        exp_t e;
        @(negedge clk);
        rst_n1 = rst; stallF = sf; stallD = sd; flushD = fl; pc_srcE = src; pc_targetE = tgt;
        e.pc = epc; e.valid = ev; e.pcd = epcd; e.mis = emis; e.tag = tag;
        q1.push_back(e);
        @(posedge clk);
    endtask

    task automatic step2(input string tag, input logic rst, input logic [31:0] epc,
                         input logic ev, input logic [31:0] epcd);
        exp_t e;
        @(negedge clk);
        rst_n2 = rst;
        e.pc = epc; e.valid = ev; e.pcd = epcd; e.mis = 1'b0; e.tag = tag;
        q2.push_back(e);
        @(posedge clk);
    endtask

    initial begin : driver
        int budget;
        rst_n1 = 1'b0; rst_n2 = 1'b0;
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; pc_srcE = 1'b0; pc_targetE = 32'h0;

        //     tag      rst sF sD fl src target        pcF           v  pcD           mis
        step1("rst0",   0,  0, 0, 0, 0, 32'h0,        32'h00,       0, 32'h0,        0);
        step1("rst1",   0,  0, 0, 0, 0, 32'h0,        32'h00,       0, 32'h0,        0);
        step1("boot",   1,  0, 0, 0, 0, 32'h0,        32'h00,       0, 32'h0,        0);
        step1("run0",   1,  0, 0, 0, 0, 32'h0,        32'h04,       1, 32'h00,       0);
        step1("run1",   1,  0, 0, 0, 0, 32'h0,        32'h08,       1, 32'h04,       0);
        step1("run2",   1,  0, 0, 0, 0, 32'h0,        32'h0C,       1, 32'h08,       0);
        step1("run3",   1,  0, 0, 0, 0, 32'h0,        32'h10,       1, 32'h0C,       0);
        step1("stl0",   1,  1, 1, 0, 0, 32'h0,        32'h10,       1, 32'h0C,       0);
        step1("stl1",   1,  1, 1, 0, 0, 32'h0,        32'h10,       1, 32'h0C,       0);
        step1("stl2",   1,  1, 1, 0, 0, 32'h0,        32'h10,       1, 32'h0C,       0);
        step1("stlrel", 1,  0, 0, 0, 0, 32'h0,        32'h14,       1, 32'h10,       0);
        step1("redir",  1,  1, 0, 0, 1, 32'h40,       32'h40,       0, 32'h0,        0);
        step1("aftred", 1,  0, 0, 0, 0, 32'h0,        32'h44,       1, 32'h40,       0);
        step1("misred", 1,  0, 0, 0, 1, 32'h43,       32'h40,       0, 32'h0,        1);
        step1("misoff", 1,  0, 0, 0, 0, 32'h0,        32'h44,       1, 32'h40,       0);
        step1("flstl",  1,  0, 1, 1, 0, 32'h0,        32'h48,       0, 32'h0,        0);
        step1("aftfl",  1,  0, 0, 0, 0, 32'h0,        32'h4C,       1, 32'h48,       0);
        step1("stlD",   1,  0, 1, 0, 0, 32'h0,        32'h50,       1, 32'h48,       0);
        step1("stlF",   1,  1, 0, 0, 0, 32'h0,        32'h50,       1, 32'h50,       0);
        step1("aftstF", 1,  0, 0, 0, 0, 32'h0,        32'h54,       1, 32'h50,       0);
        step1("mid",    1,  0, 0, 0, 1, 32'h87,       32'h84,       0, 32'h0,        1);
        step1("rstmid", 0,  1, 1, 1, 1, 32'h43,       32'h00,       0, 32'h0,        0);
`ifdef IF_PERF_CNT_EN
        #2;
        check32("rstmid.fetch_cnt", fetch_cnt1, 32'd0);
        check32("rstmid.bubble_cnt", bubble_cnt1, 32'd0);
`endif
        step1("boot2",  1,  0, 0, 0, 0, 32'h0,        32'h00,       0, 32'h0,        0);
        step1("run2_0", 1,  0, 0, 0, 0, 32'h0,        32'h04,       1, 32'h00,       0);

        //     tag      rst pcF            v  pcD
        step2("wrst",   0,  32'hFFFF_FFF8, 0, 32'h0);
        step2("wboot",  1,  32'hFFFF_FFF8, 0, 32'h0);
        step2("wrun0",  1,  32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
        step2("wrap",   1,  32'h0000_0000, 1, 32'hFFFF_FFFC);
        step2("wrun2",  1,  32'h0000_0004, 1, 32'h0000_0000);

        budget = 0;
        while ((q1.size() > 0 || q2.size() > 0) && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checks++;
        if (q1.size() > 0 || q2.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
